a2d_intf: RTL and testbench



---
 rtl/a2d_intf.sv | 147 ++++++++++++++
 tb/tb_a2d_intf.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/a2d_intf.sv
// SPI initiator for the ADC128S: two 16-bit transactions per conversion, 12-bit result out.
// Latency: 1042 clks from accepted strt_cnv to cnv_cmplt (GAP_CLKS=2); SCLK = clk/32.
// Backpressure: none; strt_cnv is ignored while a conversion is in progress.
module a2d_intf #(
    parameter int GAP_CLKS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        strt_cnv,
    input  logic [2:0]  chnnl,
    output logic        cnv_cmplt,
    output logic [11:0] res,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    typedef enum logic [1:0] {IDLE, XFER1, GAP, XFER2} state_t;

    // Counter preset while SS_n is high; the +1 applied on the lowering edge
    // puts the first SCLK rise 24 clks and the first shift 40 clks after it.
    localparam logic [4:0] DIV_LOAD = 5'b10111;
    localparam logic [4:0] RISE_VAL = 5'b01111;
    localparam logic [4:0] FALL_VAL = 5'b11111;
    localparam logic [4:0] LAST_FALL = 5'd16;
    localparam logic [3:0] GAP_LAST = 4'(GAP_CLKS - 1);

    state_t      state_q, state_d;
    logic        ss_n_q, ss_n_d;
    logic [4:0]  sclk_div_q, sclk_div_d;
    logic [4:0]  shft_cnt_q, shft_cnt_d;
    logic [15:0] shft_q, shft_d;
    logic        miso_smpl_q, miso_smpl_d;
    logic [2:0]  chnnl_q, chnnl_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic [11:0] res_q, res_d;
    logic        cnv_cmplt_q, cnv_cmplt_d;

    logic        sclk_rise;
    logic        sclk_fall;
    logic        xfer_done;

    assign sclk_rise = !ss_n_q && (sclk_div_q == RISE_VAL);
    assign sclk_fall = !ss_n_q && (sclk_div_q == FALL_VAL);
    // shft_cnt counts SCLK falls; fall 0 does not shift, so fall 16 is the 16th shift.
    assign xfer_done = sclk_fall && (shft_cnt_q == LAST_FALL);

    // Next-state, datapath and FSM decode for the whole transaction sequencer.
    always_comb begin
        state_d     = state_q;
        ss_n_d      = ss_n_q;
        sclk_div_d  = (ss_n_q ? DIV_LOAD : sclk_div_q) + 5'd1;
        shft_cnt_d  = shft_cnt_q;
        shft_d      = shft_q;
        miso_smpl_d = sclk_rise ? MISO : miso_smpl_q;
        chnnl_d     = chnnl_q;
        gap_cnt_d   = gap_cnt_q;
        res_d       = res_q;
        cnv_cmplt_d = cnv_cmplt_q;

        if (sclk_fall) begin
            shft_cnt_d = shft_cnt_q + 5'd1;
            if (shft_cnt_q != 5'd0) begin
                shft_d = {shft_q[14:0], miso_smpl_q};
            end
        end

        case (state_q)
            IDLE: begin
                if (strt_cnv) begin
                    chnnl_d     = chnnl;
                    cnv_cmplt_d = 1'b0;
                    shft_d      = {2'b00, chnnl, 11'h000};
                    shft_cnt_d  = 5'd0;
                    ss_n_d      = 1'b0;
                    state_d     = XFER1;
                end
            end
            XFER1: begin
                if (xfer_done) begin
                    ss_n_d    = 1'b1;
                    gap_cnt_d = 4'd0;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    // Same command again so the ADC channel pointer stays put.
                    shft_d     = {2'b00, chnnl_q, 11'h000};
                    shft_cnt_d = 5'd0;
                    ss_n_d     = 1'b0;
                    state_d    = XFER2;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            XFER2: begin
                if (xfer_done) begin
                    ss_n_d      = 1'b1;
                    // Result includes the bit shifted in on this final edge.
                    res_d       = {shft_q[10:0], miso_smpl_q};
                    cnv_cmplt_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                ss_n_d  = 1'b1;
            end
        endcase
    end

    // State and datapath registers; reset drops any partial transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ss_n_q      <= 1'b1;
            sclk_div_q  <= DIV_LOAD;
            shft_cnt_q  <= 5'd0;
            shft_q      <= 16'h0000;
            miso_smpl_q <= 1'b0;
            chnnl_q     <= 3'd0;
            gap_cnt_q   <= 4'd0;
            res_q       <= 12'h000;
            cnv_cmplt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ss_n_q      <= ss_n_d;
            sclk_div_q  <= sclk_div_d;
            shft_cnt_q  <= shft_cnt_d;
            shft_q      <= shft_d;
            miso_smpl_q <= miso_smpl_d;
            chnnl_q     <= chnnl_d;
            gap_cnt_q   <= gap_cnt_d;
            res_q       <= res_d;
            cnv_cmplt_q <= cnv_cmplt_d;
        end
    end

    assign SS_n      = ss_n_q;
    assign SCLK      = ss_n_q ? 1'b1 : sclk_div_q[4];
    assign MOSI      = shft_q[15];
    assign res       = res_q;
    assign cnv_cmplt = cnv_cmplt_q;

endmodule

// File: tb/tb_a2d_intf.sv
// Bench for a2d_intf: ADC128S behavioural model plus scoreboard of commands and results.
// Checks command words, SCLK counts, SS_n low time, result and completion latency.
// Randomized ADC data per channel; directed busy, reset and extreme-data scenarios.
`timescale 1ns/1ps
module tb_a2d_intf;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        strt_cnv = 1'b0;
    logic [2:0]  chnnl = 3'd0;
    logic        MISO = 1'b0;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;

    always #5 clk = ~clk;

    a2d_intf #(.GAP_CLKS(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .strt_cnv  (strt_cnv),
        .chnnl     (chnnl),
        .cnv_cmplt (cnv_cmplt),
        .res       (res),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard queues, filled by the driver when a conversion is issued.
    logic [15:0] exp_cmd_q [$];
    logic [11:0] exp_res_q [$];
    time         exp_t0_q  [$];

    // ADC128S model: per-channel data, addressed by the previous transaction's command.
    logic [11:0] adc_data [8];
    logic [2:0]  adc_ch = 3'd0;
    logic [15:0] adc_word = 16'h0000;
    logic [15:0] mosi_word = 16'h0000;
    int          mi_idx = 0;
    int          rises_x = 0;
    int          rise_total = 0;
    int          sclk_tog = 0;
    time         fall_t = 0;

    always @(SCLK) sclk_tog++;

    always @(negedge SS_n) begin
        adc_word  = {4'b0000, adc_data[adc_ch]};
        mi_idx    = 15;
        MISO      = adc_word[15];
        rises_x   = 0;
        mosi_word = 16'h0000;
        fall_t    = $time;
    end

    always @(posedge SCLK) begin
        if (SS_n === 1'b0) begin
            mosi_word = {mosi_word[14:0], MOSI};
            rises_x++;
            rise_total++;
        end
    end

    always @(negedge SCLK) begin
        if (SS_n === 1'b0 && rises_x > 0 && mi_idx > 0) begin
            mi_idx--;
            MISO = adc_word[mi_idx];
        end
    end

    // Transaction monitor: each completed SS_n frame is compared to the next expected command.
    always @(posedge SS_n) begin
        if (rst !== 1'b1) begin
            check("ss_n_low_clks", 32'(($time - fall_t) / 10), 32'd520);
            check("sclk_rises_per_xfer", 32'(rises_x), 32'd16);
            if (exp_cmd_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_xfer: got cmd 0x%0h, expected no transaction", mosi_word);
            end else begin
                check("mosi_cmd", {16'h0, mosi_word}, {16'h0, exp_cmd_q.pop_front()});
            end
            adc_ch = mosi_word[13:11];
        end
    end

    // Completion monitor: result and latency compared on each cnv_cmplt rise.
    logic prev_cmplt = 1'b0;
    always @(negedge clk) begin
        if (rst !== 1'b1 && cnv_cmplt === 1'b1 && prev_cmplt === 1'b0) begin
            if (exp_res_q.size() == 0 || exp_t0_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_cmplt: got res 0x%0h, expected no completion", res);
            end else begin
                check("res", {20'h0, res}, {20'h0, exp_res_q.pop_front()});
                check("cmplt_latency_clks", 32'(($time - 5 - exp_t0_q.pop_front()) / 10), 32'd1042);
            end
        end
        prev_cmplt = cnv_cmplt;
    end

    task automatic start(input logic [2:0] ch);
        logic [15:0] cmd;
        cmd = {2'b00, ch, 11'h000};
        @(negedge clk);
        chnnl    = ch;
        strt_cnv = 1'b1;
        exp_cmd_q.push_back(cmd);
        exp_cmd_q.push_back(cmd);
        exp_res_q.push_back(adc_data[ch]);
        @(posedge clk);
        exp_t0_q.push_back($time);
        #1;
        strt_cnv = 1'b0;
        check("cmplt_cleared_on_start", {31'h0, cnv_cmplt}, 32'd0);
        check("ss_n_low_after_e0", {31'h0, SS_n}, 32'd0);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (cnv_cmplt !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            total++;
            bad++;
            $display("FAIL cmplt_timeout: got no cnv_cmplt, expected one within 3000 clks");
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic hold_check(input logic [11:0] want);
        repeat (40) @(negedge clk);
        check("res_hold", {20'h0, res}, {20'h0, want});
        check("cmplt_hold", {31'h0, cnv_cmplt}, 32'd1);
        check("ss_n_idle", {31'h0, SS_n}, 32'd1);
    endtask

    initial begin
        int r0;
        int t0;
        for (int i = 0; i < 8; i++) adc_data[i] = 12'($urandom);

        // Reset only
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ss_n", {31'h0, SS_n}, 32'd1);
        check("rst_sclk", {31'h0, SCLK}, 32'd1);
        check("rst_mosi", {31'h0, MOSI}, 32'd0);
        check("rst_cmplt", {31'h0, cnv_cmplt}, 32'd0);
        check("rst_res", {20'h0, res}, 32'd0);
        t0 = sclk_tog;
        repeat (2000) @(posedge clk);
        check("idle_sclk_toggles", 32'(sclk_tog - t0), 32'd0);
        check("idle_ss_n", {31'h0, SS_n}, 32'd1);

        // Single conversion, channel 3
        adc_data[3] = 12'hA5C;
        r0 = rise_total;
        start(3'd3);
        wait_done();
        check("single_rises", 32'(rise_total - r0), 32'd32);
        hold_check(12'hA5C);

        // Channel sweep with random data
        for (int ch = 0; ch < 8; ch++) begin
            adc_data[ch] = 12'($urandom);
            start(3'(ch));
            wait_done();
        end

        // Busy rejection: second request at E300 must be ignored
        adc_data[5] = 12'($urandom);
        adc_data[2] = ~adc_data[5];
        r0 = rise_total;
        start(3'd5);
        repeat (299) @(posedge clk);
        @(negedge clk);
        chnnl    = 3'd2;
        strt_cnv = 1'b1;
        @(posedge clk);
        #1;
        strt_cnv = 1'b0;
        wait_done();
        check("busy_rises", 32'(rise_total - r0), 32'd32);
        hold_check(adc_data[5]);

        // Reset mid-XFER2
        start(3'd1);
        repeat (700) @(posedge clk);
        rst = 1'b1;
        #1;
        check("midrst_ss_n", {31'h0, SS_n}, 32'd1);
        check("midrst_sclk", {31'h0, SCLK}, 32'd1);
        check("midrst_cmplt", {31'h0, cnv_cmplt}, 32'd0);
        check("midrst_res", {20'h0, res}, 32'd0);
        exp_cmd_q.delete();
        exp_res_q.delete();
        exp_t0_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("postrst_res", {20'h0, res}, 32'd0);
        adc_data[4] = 12'($urandom);
        start(3'd4);
        wait_done();
        hold_check(adc_data[4]);

        // Extreme data on consecutive conversions
        adc_data[7] = 12'hFFF;
        start(3'd7);
        wait_done();
        check("extreme_fff", {20'h0, res}, 32'h0000_0FFF);
        adc_data[7] = 12'h000;
        start(3'd7);
        wait_done();
        check("extreme_000", {20'h0, res}, 32'd0);
        check("final_cmplt", {31'h0, cnv_cmplt}, 32'd1);

        check("scoreboard_drained", 32'(exp_cmd_q.size() + exp_res_q.size() + exp_t0_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no end of test, expected completion before 5 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
